adder_ppn_core: RTL

ADDER_PPN_CORE -- requirements
Module: adder_ppn_core

---
 rtl/adder_ppn_core_pkg.sv | 34 +++
 rtl/adder_ppn_lane.sv | 104 ++++++++++
 rtl/adder_ppn_core.sv | 97 +++++++++
 3 files changed

// File: rtl/adder_ppn_core_pkg.sv
// ---------------------------------------------------------------------------
// adder_ppn_core_pkg
// Shared helpers for the pipelined carry-segmented adder.
//   ceil_div  : integer ceiling division
//   seg_lo    : first bit of carry segment k (segment S returns the full width)
//   seg_width : width of carry segment k (always >= 1 when stages <= width)
// ---------------------------------------------------------------------------
package adder_ppn_core_pkg;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    // Segments are ceil(w/s) bits wide, LSB first, and the top segment takes
    // the remainder. The start is clamped so every later segment keeps at
    // least one bit, which stops the top segment collapsing to zero width
    // for awkward width/stage combinations.
    function automatic int seg_lo(input int k, input int w, input int s);
        int lo;
        if (k >= s) begin
            return w;
        end
        lo = k * ceil_div(w, s);
        if (lo > w - (s - k)) begin
            lo = w - (s - k);
        end
        return lo;
    endfunction

    function automatic int seg_width(input int k, input int w, input int s);
        return seg_lo(k + 1, w, s) - seg_lo(k, w, s);
    endfunction

endpackage

// File: rtl/adder_ppn_lane.sv
// ---------------------------------------------------------------------------
// adder_ppn_lane
// One lane of the pipelined adder: operand extension, add/subtract select
// and a C_STAGES-deep carry-segmented ripple.
//   I_clk, I_rst_n  : clock, synchronous active-low reset
//   I_ce            : pipeline advance enable
//   I_signed, I_sub : mode of the sample presented this cycle
//   I_a, I_b        : operands (C_IN1 / C_IN2 bits)
//   O_sum           : exact C_W = C_IN+1 bit result, C_STAGES enabled cycles later
// ---------------------------------------------------------------------------
module adder_ppn_lane
    import adder_ppn_core_pkg::*;
#(
    parameter int C_IN1    = 12,
    parameter int C_IN2    = 12,
    parameter int C_IN     = 12,
    parameter int C_STAGES = 2
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic              I_ce,
    input  logic              I_signed,
    input  logic              I_sub,
    input  logic [C_IN1-1:0]  I_a,
    input  logic [C_IN2-1:0]  I_b,
    output logic [C_IN:0]     O_sum
);

    localparam int C_W = C_IN + 1;

    logic [C_W-1:0] a_ext;
    logic [C_W-1:0] b_ext;
    logic [C_W-1:0] b_eff;

    // Widening by one bit over C_IN makes the sum exact in both modes.
    assign a_ext = {{(C_W - C_IN1){I_signed & I_a[C_IN1-1]}}, I_a};
    assign b_ext = {{(C_W - C_IN2){I_signed & I_b[C_IN2-1]}}, I_b};
    // Subtraction is A + ~B + 1; the +1 enters as the stage-0 carry-in.
    assign b_eff = I_sub ? ~b_ext : b_ext;

    for (genvar k = 0; k < C_STAGES; k++) begin : g_stage
        localparam int LO  = seg_lo(k, C_W, C_STAGES);
        localparam int WD  = seg_width(k, C_W, C_STAGES);
        localparam int WDP = WD + 1;
        localparam int HI  = LO + WD;

        // a_in/b_in hold only the operand bits not yet added; s_q holds the
        // completed low result bits, so both shrink/grow stage by stage.
        logic [C_W-LO-1:0] a_in;
        logic [C_W-LO-1:0] b_in;
        logic              c_in;
        logic [WD-1:0]     seg_sum;
        logic [HI-1:0]     s_nxt;
        logic [HI-1:0]     s_q;

        if (k == 0) begin : g_first
            assign a_in  = a_ext;
            assign b_in  = b_eff;
            assign c_in  = I_sub;
            assign s_nxt = seg_sum;
        end else begin : g_next
            assign a_in  = g_stage[k-1].g_pass.a_q;
            assign b_in  = g_stage[k-1].g_pass.b_q;
            assign c_in  = g_stage[k-1].g_pass.c_q;
            assign s_nxt = {seg_sum, g_stage[k-1].s_q};
        end

        if (k < C_STAGES - 1) begin : g_pass
            logic [WD:0]       sum_full;
            logic [C_W-HI-1:0] a_q;
            logic [C_W-HI-1:0] b_q;
            logic              c_q;

            assign sum_full = {1'b0, a_in[WD-1:0]} + {1'b0, b_in[WD-1:0]} + WDP'(c_in);
            assign seg_sum  = sum_full[WD-1:0];

            always_ff @(posedge I_clk) begin
                if (!I_rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                    c_q <= 1'b0;
                end else if (I_ce) begin
                    a_q <= a_in[C_W-LO-1:WD];
                    b_q <= b_in[C_W-LO-1:WD];
                    c_q <= sum_full[WD];
                end
            end
        end else begin : g_last
            // Final carry-out is dropped: the C_W-bit result is already exact.
            assign seg_sum = a_in + b_in + WD'(c_in);
        end

        always_ff @(posedge I_clk) begin
            if (!I_rst_n) begin
                s_q <= '0;
            end else if (I_ce) begin
                s_q <= s_nxt;
            end
        end
    end

    assign O_sum = g_stage[C_STAGES-1].s_q;

endmodule

// File: rtl/adder_ppn_core.sv
// ---------------------------------------------------------------------------
// adder_ppn_core
// Multi-lane pipelined add/subtract with a shared valid/mode pipeline.
//   I_clk     : clock, rising edge
//   I_rst_n   : synchronous active-low reset (wins over I_ce)
//   I_ce      : advance enable; when low every register holds
//   I_valid   : sample valid (no back-pressure; a sample is accepted on any
//               edge with I_valid & I_ce and appears on O_valid exactly
//               C_STAGES enabled edges later; O_dout is meaningful only
//               while O_valid is high)
//   I_signed  : 1 = two's-complement operands
//   I_sub     : 1 = A - B
//   I_a, I_b  : C_LANES packed operand lanes, lane 0 in the LSBs
//   O_valid   : result valid
//   O_dout    : C_LANES packed C_OUT-bit results
// ---------------------------------------------------------------------------
module adder_ppn_core
    import adder_ppn_core_pkg::*;
#(
    parameter int C_IN1    = 12,
    parameter int C_IN2    = 12,
    parameter int C_IN     = 12,
    parameter int C_OUT    = 13,
    parameter int C_STAGES = 2,
    parameter int C_LANES  = 1
) (
    input  logic                       I_clk,
    input  logic                       I_rst_n,
    input  logic                       I_ce,
    input  logic                       I_valid,
    input  logic                       I_signed,
    input  logic                       I_sub,
    input  logic [C_LANES*C_IN1-1:0]   I_a,
    input  logic [C_LANES*C_IN2-1:0]   I_b,
    output logic                       O_valid,
    output logic [C_LANES*C_OUT-1:0]   O_dout
);

    localparam int C_W = C_IN + 1;

    logic [C_STAGES-1:0] v_q;
    logic [C_W-1:0]      sum_w [C_LANES];

    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            v_q <= '0;
        end else if (I_ce) begin
            v_q <= (v_q << 1) | C_STAGES'(I_valid);
        end
    end

    assign O_valid = v_q[C_STAGES-1];

    // I_sub and the operand-extension use of I_signed are consumed as the
    // sample enters stage 0; only the output-extension mode has to travel.
    for (genvar l = 0; l < C_LANES; l++) begin : g_lane
        adder_ppn_lane #(
            .C_IN1    (C_IN1),
            .C_IN2    (C_IN2),
            .C_IN     (C_IN),
            .C_STAGES (C_STAGES)
        ) u_lane (
            .I_clk    (I_clk),
            .I_rst_n  (I_rst_n),
            .I_ce     (I_ce),
            .I_signed (I_signed),
            .I_sub    (I_sub),
            .I_a      (I_a[l*C_IN1 +: C_IN1]),
            .I_b      (I_b[l*C_IN2 +: C_IN2]),
            .O_sum    (sum_w[l])
        );
    end

    if (C_OUT > C_W) begin : g_ext
        // Captured I_signed travels with its sample to choose the extension.
        logic [C_STAGES-1:0] sg_q;

        always_ff @(posedge I_clk) begin
            if (!I_rst_n) begin
                sg_q <= '0;
            end else if (I_ce) begin
                sg_q <= (sg_q << 1) | C_STAGES'(I_signed);
            end
        end

        for (genvar l = 0; l < C_LANES; l++) begin : g_map
            assign O_dout[l*C_OUT +: C_OUT] =
                {{(C_OUT - C_W){sg_q[C_STAGES-1] & sum_w[l][C_W-1]}}, sum_w[l]};
        end
    end else begin : g_trunc
        // Narrower output wraps: keep the low C_OUT bits.
        for (genvar l = 0; l < C_LANES; l++) begin : g_map
            assign O_dout[l*C_OUT +: C_OUT] = sum_w[l][C_OUT-1:0];
        end
    end

endmodule
